// File: rtl/mem_line_responder.sv
// -----------------------------------------------------------------------------
// mem_line_responder
//
// Memory-side responder for the cache line interface. Each request moves one
// 128-bit line by sequencing four 32-bit accesses to a single-port word SRAM.
// One instance sits behind each cache.
//
// Parameters
//   SRAM_AW      SRAM word-address width; sram_addr = {line bits, beat}.
//                Upper line-address bits beyond the SRAM are dropped.
//   WAIT_CYCLES  idle cycles inserted before the first SRAM access
//                (only used when MEM_RESP_WAIT_EN is defined).
//
// Optional feature macro
//   MEM_RESP_WAIT_EN  adds a WAIT state that delays every transaction by
//                     WAIT_CYCLES cycles. Undefined: no WAIT state/counter.
//
// Ports
//   clk, proc_reset        clock, synchronous active-high reset
//   mem_read, mem_write    line requests, held by the cache until mem_ready
//   mem_addr               line address [31:4]
//   mem_wdata              write line, word k = bits [32k+31:32k]
//   mem_rdata              registered read line, valid with mem_ready on reads
//   mem_ready              registered one-cycle completion pulse
//   sram_ren, sram_wen     SRAM word read / write enables (never both high)
//   sram_addr, sram_wdata  SRAM word address / write word
//   sram_rdata             SRAM read word, valid the cycle after sram_ren
//   req_err                sticky flag: read and write requested together
// -----------------------------------------------------------------------------
module mem_line_responder #(
  parameter int SRAM_AW     = 14,
  parameter int WAIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               proc_reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [27:0]        mem_addr,
  input  logic [127:0]       mem_wdata,
  output logic [127:0]       mem_rdata,
  output logic               mem_ready,
  output logic               sram_ren,
  output logic               sram_wen,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic               req_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
`ifdef MEM_RESP_WAIT_EN
    S_WAIT    = 3'd6,
`endif
    S_RD      = 3'd1,
    S_RD_TAIL = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic [1:0]              beat;
  logic                    is_write;
  logic [SRAM_AW-3:0]      line_addr;
  // Holds the write line on writes and assembles read words on reads.
  logic [3:0][31:0]        line_buf;
  logic                    req_seen;
  state_t                  op_state;

  // Address bits above the SRAM size are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[27:SRAM_AW-2];

  assign req_seen = mem_read | mem_write;

`ifdef MEM_RESP_WAIT_EN
  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [WCW-1:0] wait_cnt;
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

  // State register.
  // NOTE: the reset is synchronous, so it lives inside the clocked branch and
  // only takes effect on a rising edge.
  always_ff @(posedge clk) begin
    if (proc_reset) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_nxt = state;
    op_state  = mem_write ? S_WR : S_RD;  // write wins when both are high
    case (state)
      S_IDLE: begin
        if (req_seen) begin
`ifdef MEM_RESP_WAIT_EN
          state_nxt = (WAIT_CYCLES == 0) ? op_state : S_WAIT;
`else
          state_nxt = op_state;
`endif
        end
      end
`ifdef MEM_RESP_WAIT_EN
      S_WAIT:    if (wait_cnt == WCW'(WAIT_CYCLES - 1))
                   state_nxt = is_write ? S_WR : S_RD;
`endif
      S_RD:      if (beat == 2'd3) state_nxt = S_RD_TAIL;
      S_RD_TAIL: state_nxt = S_DONE;
      S_WR:      if (beat == 2'd3) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_GAP;
      S_GAP:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // SRAM side: enables straight from the state; address/data only driven
  // while an access is in progress so they read as zero otherwise.
  always_comb begin
    sram_ren   = (state == S_RD);
    sram_wen   = (state == S_WR);
    sram_addr  = '0;
    sram_wdata = '0;
    if (sram_ren || sram_wen) sram_addr = {line_addr, beat};
    if (sram_wen)             sram_wdata = line_buf[beat];
  end

  // Datapath registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      beat      <= '0;
      is_write  <= 1'b0;
      line_addr <= '0;
      line_buf  <= '0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      req_err   <= 1'b0;
`ifdef MEM_RESP_WAIT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      mem_ready <= 1'b0;

      if (state == S_IDLE && req_seen) begin
        is_write  <= mem_write;
        line_addr <= mem_addr[SRAM_AW-3:0];
        line_buf  <= mem_wdata;
        if (mem_read && mem_write) req_err <= 1'b1;
      end

      // Beat advances through the 4 accesses and naturally wraps 3->0 on exit.
      if (state == S_RD || state == S_WR) beat <= beat + 2'd1;

      // Read data lags its enable by one cycle: capture word beat-1. In
      // RD_TAIL beat has wrapped to 0, so beat-1 selects word 3.
      if ((state == S_RD && beat != 2'd0) || state == S_RD_TAIL)
        line_buf[beat - 2'd1] <= sram_rdata;

      if (state == S_RD_TAIL) begin
        mem_ready <= 1'b1;
        mem_rdata <= {sram_rdata, line_buf[2], line_buf[1], line_buf[0]};
      end

      if (state == S_WR && beat == 2'd3) mem_ready <= 1'b1;

`ifdef MEM_RESP_WAIT_EN
      if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                 wait_cnt <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_line_responder
//
// Directed bench for mem_line_responder: a vector table of line requests with
// hand-computed expected data, followed by hand-written sequences for
// back-to-back requests and reset in the middle of a transaction. A small
// behavioural word SRAM sits on the SRAM port.
// -----------------------------------------------------------------------------
module tb_mem_line_responder;

  localparam int AW = 14;
`ifdef MEM_RESP_WAIT_EN
  localparam int EXTRA = 4;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [127:0] L1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] L2 = 128'h8888_8888_7777_7777_6666_6666_5555_5555;
  localparam logic [127:0] L3 = 128'hCCCC_CCCC_BBBB_BBBB_AAAA_AAAA_9999_9999;
  localparam logic [127:0] L4 = 128'h0F0F_0F0F_1234_5678_DEAD_BEEF_CAFE_F00D;
  localparam logic [127:0] L5 = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          mem_read, mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;
  logic          sram_ren, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;
  logic          req_err;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_line_responder #(.SRAM_AW(AW), .WAIT_CYCLES(4)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .sram_ren   (sram_ren),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .req_err    (req_err)
  );

  // Behavioural single-port SRAM, one cycle read latency.
  bit [31:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_wen) sram_mem[sram_addr] <= sram_wdata;
    if (sram_ren) sram_rdata <= sram_mem[sram_addr];
  end

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic         drop;       // cache drops request after one cycle
    logic [127:0] exp_rdata;  // mem_rdata expected at completion
    logic         exp_err;
  } vec_t;

  // Issues one request and follows it to completion and through GAP.
  task automatic do_req(input vec_t v, input bit reassert_wr);
    bit got = 1'b0;
    int lat = 0;
    int nb  = 0;
    @(negedge clk);
    mem_read  = v.rd;
    mem_write = v.wr;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (v.drop) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      if (sram_ren || sram_wen) begin
        check({v.name, " sram_op"}, 128'({sram_ren, sram_wen}),
              128'({!v.wr, v.wr}));
        check({v.name, " sram_addr"}, 128'(sram_addr),
              128'({v.addr[AW-3:0], nb[1:0]}));
        if (sram_wen && nb < 4)
          check({v.name, " sram_wdata"}, 128'(sram_wdata),
                128'(v.wdata[32*nb +: 32]));
        nb++;
      end
      if (mem_ready) begin
        got = 1'b1;
        lat = c;
        check({v.name, " mem_rdata"}, mem_rdata, v.exp_rdata);
        mem_read  = 1'b0;
        mem_write = reassert_wr;
      end
    end
    check({v.name, " latency"}, 128'(lat), 128'((v.wr ? 5 : 6) + EXTRA));
    check({v.name, " beats"}, 128'(nb), 128'(4));
    check({v.name, " req_err"}, 128'(req_err), 128'(v.exp_err));
    @(negedge clk);  // GAP cycle
    check({v.name, " ready_one_cycle"}, 128'(mem_ready), 128'(0));
    check({v.name, " gap_no_sram"}, 128'({sram_ren, sram_wen}), 128'(0));
  endtask

  vec_t vecs [8];
  vec_t tmp;

  initial begin
    int first_wen, ready_at, ready_cnt;

    vecs[0] = '{"wr_line1",     0, 1, 28'h0000001, L1, 0, 128'h0, 0};
    vecs[1] = '{"rd_line1",     1, 0, 28'h0000001, '0, 0, L1,     0};
    vecs[2] = '{"wr_line2_drop",0, 1, 28'h0000002, L2, 1, L1,     0};
    vecs[3] = '{"rd_alias1",    1, 0, 28'h0001001, '0, 0, L1,     0};
    vecs[4] = '{"rd_line2_drop",1, 0, 28'h0000002, '0, 1, L2,     0};
    vecs[5] = '{"rdwr_both",    1, 1, 28'h0000002, L3, 0, L2,     1};
    vecs[6] = '{"rd_line2_new", 1, 0, 28'h0000002, '0, 0, L3,     1};
    vecs[7] = '{"rd_line1_err", 1, 0, 28'h0000001, '0, 0, L1,     1};

    proc_reset = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready_en_err", 128'({mem_ready, sram_ren, sram_wen, req_err}),
          128'(0));
    check("reset mem_rdata", mem_rdata, 128'(0));
    check("reset sram_bus", 128'({sram_addr, sram_wdata}), 128'(0));
    proc_reset = 1'b0;

    for (int i = 0; i < 8; i++) do_req(vecs[i], 1'b0);

    // Back-to-back: cache re-asserts a write while DONE is showing mem_ready.
    tmp = '{"b2b_rd", 1, 0, 28'h0000001, '0, 0, L1, 1};
    do_req(tmp, 1'b1);
    mem_addr  = 28'h0000004;
    mem_wdata = L4;
    first_wen = 0;
    ready_at  = 0;
    ready_cnt = 0;
    for (int c = 1; c <= 14 + EXTRA; c++) begin
      @(negedge clk);
      if (sram_wen && first_wen == 0) first_wen = c;
      if (mem_ready) begin
        ready_cnt++;
        if (ready_at == 0) ready_at = c;
        mem_write = 1'b0;
      end
    end
    check("b2b first_wen", 128'(first_wen), 128'(2 + EXTRA));
    check("b2b ready_at", 128'(ready_at), 128'(6 + EXTRA));
    check("b2b ready_cnt", 128'(ready_cnt), 128'(1));
    tmp = '{"b2b_rdback", 1, 0, 28'h0000004, '0, 0, L4, 1};
    do_req(tmp, 1'b0);

    // Reset during RD beat 2: no completion, sticky error cleared.
    @(negedge clk);
    mem_read = 1'b1;
    mem_addr = 28'h0000001;
    repeat (3 + EXTRA) @(negedge clk);
    check("rst_rd at_beat2", 128'({sram_ren, sram_addr}),
          128'({1'b1, 14'h0006}));
    proc_reset = 1'b1;
    mem_read   = 1'b0;
    @(negedge clk);
    check("rst_rd idle", 128'({mem_ready, sram_ren, sram_wen}), 128'(0));
    check("rst_rd err_clr", 128'(req_err), 128'(0));
    proc_reset = 1'b0;
    ready_cnt  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_ready || sram_ren || sram_wen) ready_cnt++;
    end
    check("rst_rd no_activity", 128'(ready_cnt), 128'(0));

    // Reset during WR beat 2: words 0..2 already written stay written.
    mem_write = 1'b1;
    mem_addr  = 28'h0000003;
    mem_wdata = L5;
    repeat (3 + EXTRA) @(negedge clk);
    check("rst_wr at_beat2", 128'({sram_wen, sram_addr, sram_wdata}),
          128'({1'b1, 14'h000E, 32'hCCCC_CCCC}));
    proc_reset = 1'b1;
    mem_write  = 1'b0;
    @(negedge clk);
    check("rst_wr idle", 128'({mem_ready, sram_ren, sram_wen}), 128'(0));
    proc_reset = 1'b0;
    tmp = '{"rd_partial", 1, 0, 28'h0000003, '0, 0,
            128'h0000_0000_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, 0};
    do_req(tmp, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
